// File: rtl/funnel_fanout_buffered_if.sv
`default_nettype none
// ============================================================================
//  Module      : funnel_fanout_buffered_if
//  Description : Handshake bundle for funnel_fanout_buffered. It carries one
//                tagged input pipe, FANOUT_WIDTH output lanes and the drop
//                pulse. The master side is the producer/consumer environment.
//                The slave side is the fan-out block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface funnel_fanout_buffered_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int FANOUT_WIDTH = 4,
  parameter int TAG_WIDTH    = 8
);
  logic                               in_enq__ENA;
  logic [TAG_WIDTH+DATA_WIDTH-1:0]    in_enq_v;
  logic                               in_enq__RDY;
  logic [FANOUT_WIDTH-1:0]            out_enq__ENA;
  logic [FANOUT_WIDTH*DATA_WIDTH-1:0] out_enq_v;
  logic [FANOUT_WIDTH-1:0]            out_enq__RDY;
  logic                               err_drop;

  modport master (
    output in_enq__ENA, in_enq_v, out_enq__RDY,
    input  in_enq__RDY, out_enq__ENA, out_enq_v, err_drop
  );

  modport slave (
    input  in_enq__ENA, in_enq_v, out_enq__RDY,
    output in_enq__RDY, out_enq__ENA, out_enq_v, err_drop
  );
endinterface
`default_nettype wire

// File: rtl/funnel_fanout_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : funnel_fanout_buffered
//  Description : Splits one tagged input pipe across FANOUT_WIDTH output
//                lanes. A single hold register feeds one private FIFO per
//                lane, so each lane drains independently. Beats whose tag has
//                no lane are dropped, and err_drop pulses for each drop.
//                Optional macro FUNNEL_FANOUT_BROADCAST_EN: an all-ones tag
//                pushes the beat into every lane in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module funnel_fanout_buffered #(
  parameter int DATA_WIDTH   = 32,
  parameter int FANOUT_WIDTH = 4,
  parameter int TAG_WIDTH    = 8,
  parameter int DEPTH        = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  funnel_fanout_buffered_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic                    hold_valid;
  logic [TAG_WIDTH-1:0]    hold_tag;
  logic [DATA_WIDTH-1:0]   hold_data;

  logic [FANOUT_WIDTH-1:0] tag_onehot;
  logic [FANOUT_WIDTH-1:0] lane_full;
  logic [FANOUT_WIDTH-1:0] lane_empty;
  logic [FANOUT_WIDTH-1:0] lane_push;
  logic [FANOUT_WIDTH-1:0] lane_pop;
  logic [DATA_WIDTH-1:0]   lane_head [FANOUT_WIDTH];
  logic [FANOUT_WIDTH*DATA_WIDTH-1:0] out_data;

  logic tag_bad;
  logic tag_lane_full;
  logic hold_move;
  logic drop;
  logic in_rdy;

  // Decode the held tag to a lane select; out-of-range tags decode to zero
  always_comb begin
    tag_onehot = '0;
    for (int i = 0; i < FANOUT_WIDTH; i++) begin
      tag_onehot[i] = (hold_tag == TAG_WIDTH'(i));
    end
  end

  assign tag_bad       = (hold_tag >= TAG_WIDTH'(FANOUT_WIDTH));
  assign tag_lane_full = |(lane_full & tag_onehot);

`ifdef FUNNEL_FANOUT_BROADCAST_EN
  logic bcast;
  assign bcast = (hold_tag == {TAG_WIDTH{1'b1}});

  // Dispatch: a broadcast waits for every lane to have room
  always_comb begin
    hold_move = 1'b0;
    lane_push = '0;
    drop      = 1'b0;
    if (hold_valid) begin
      if (bcast) begin
        hold_move = ~|lane_full;
        lane_push = {FANOUT_WIDTH{hold_move}};
      end else if (tag_bad) begin
        hold_move = 1'b1;
        drop      = 1'b1;
      end else begin
        hold_move = !tag_lane_full;
        lane_push = hold_move ? tag_onehot : '0;
      end
    end
  end
`else
  // Dispatch: a good tag waits for its lane, a bad tag is dropped at once
  always_comb begin
    hold_move = 1'b0;
    lane_push = '0;
    drop      = 1'b0;
    if (hold_valid) begin
      if (tag_bad) begin
        hold_move = 1'b1;
        drop      = 1'b1;
      end else begin
        hold_move = !tag_lane_full;
        lane_push = hold_move ? tag_onehot : '0;
      end
    end
  end
`endif

  // The input is ready when the hold register is free or is leaving this cycle
  assign in_rdy = !hold_valid || hold_move;

  // Hold register: reload on accept, otherwise drain on move
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold_valid <= 1'b0;
      hold_tag   <= '0;
      hold_data  <= '0;
    end else if (bus.in_enq__ENA && in_rdy) begin
      hold_valid <= 1'b1;
      hold_tag   <= bus.in_enq_v[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
      hold_data  <= bus.in_enq_v[DATA_WIDTH-1:0];
    end else if (hold_move) begin
      hold_valid <= 1'b0;
    end
  end

  generate
    for (genvar i = 0; i < FANOUT_WIDTH; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0]      wr_ptr;
      logic [PTR_W-1:0]      rd_ptr;

      // The pointers carry one extra wrap bit so full and empty can be told apart
      assign lane_empty[i] = (wr_ptr == rd_ptr);
      assign lane_full[i]  = ((wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}});
      assign lane_pop[i]   = !lane_empty[i] && bus.out_enq__RDY[i];
      assign lane_head[i]  = mem[rd_ptr[ADDR_W-1:0]];

      // Advance the pointers. Push is already gated by full, so there is no bypass
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (lane_push[i]) wr_ptr <= wr_ptr + PTR_W'(1);
          if (lane_pop[i])  rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end

      // Storage write, payload only
      always_ff @(posedge CLK) begin
        if (lane_push[i]) mem[wr_ptr[ADDR_W-1:0]] <= hold_data;
      end
    end
  endgenerate

  // Pack the lane heads onto the flat output bus
  always_comb begin
    out_data = '0;
    for (int i = 0; i < FANOUT_WIDTH; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_head[i];
    end
  end

  assign bus.in_enq__RDY  = in_rdy;
  assign bus.out_enq__ENA = lane_pop;
  assign bus.out_enq_v    = out_data;
  assign bus.err_drop     = drop;

endmodule
`default_nettype wire

// File: tb/tb_funnel_fanout_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_funnel_fanout_buffered
//  Description : Self-checking bench for funnel_fanout_buffered. It runs a
//                cycle table and then directed multi-cycle sequences.
//                Define FUNNEL_FANOUT_BROADCAST_EN for the broadcast build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_funnel_fanout_buffered;
  localparam int DW    = 32;
  localparam int FW    = 4;
  localparam int TW    = 8;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  funnel_fanout_buffered_if #(.DATA_WIDTH(DW), .FANOUT_WIDTH(FW), .TAG_WIDTH(TW)) bus ();

  funnel_fanout_buffered #(
    .DATA_WIDTH(DW), .FANOUT_WIDTH(FW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [FW-1:0] rdy;
    logic          ena;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          exp_rdy;
    logic [FW-1:0] exp_ena;
    logic          exp_err;
    logic [DW-1:0] exp_d;
  } vec_t;

  typedef struct {
    int            lane;
    logic [DW-1:0] data;
  } ev_t;

  vec_t vecs[$];
  ev_t  log_q[$];
  bit   tog_run = 1'b0;

  // Record every lane pop seen mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < FW; i++) begin
        if (bus.out_enq__ENA[i]) begin
          ev_t e;
          e.lane = i;
          e.data = bus.out_enq_v[i*DW +: DW];
          log_q.push_back(e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [FW-1:0] rdy, input logic ena, input logic [TW-1:0] tag,
                              input logic [DW-1:0] d, input logic er, input logic [FW-1:0] ee,
                              input logic eerr, input logic [DW-1:0] ed);
    vec_t v;
    v.rdy = rdy; v.ena = ena; v.tag = tag; v.data = d;
    v.exp_rdy = er; v.exp_ena = ee; v.exp_err = eerr; v.exp_d = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat only while the input is ready, bounded
  task automatic send(input logic [TW-1:0] tag, input logic [DW-1:0] d);
    int n = 0;
    while (!bus.in_enq__RDY && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_enq__RDY) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tag %0h still blocked, got rdy=0 expected rdy=1", tag);
    end else begin
      bus.in_enq__ENA = 1'b1;
      bus.in_enq_v    = {tag, d};
      tick();
      bus.in_enq__ENA = 1'b0;
    end
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (log_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL wait_log: got %0d events expected %0d", log_q.size(), n);
    end
    repeat (4) tick();
  endtask

  task automatic check_ev(input string name, input int idx, input int lane, input logic [DW-1:0] d);
    if (idx >= log_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s: event %0d missing, got none expected lane %0d data %0h", name, idx, lane, d);
    end else begin
      check($sformatf("%s_lane%0d", name, idx), 64'(log_q[idx].lane), 64'(lane));
      check($sformatf("%s_data%0d", name, idx), 64'(log_q[idx].data), 64'(d));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_enq__ENA  = 1'b0;
    bus.in_enq_v     = '0;
    bus.out_enq__RDY = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Idle state just after reset
    @(negedge clk);
    check("reset_in_rdy", 64'(bus.in_enq__RDY), 64'd1);
    check("reset_out_ena", 64'(bus.out_enq__ENA), 64'd0);
    check("reset_err", 64'(bus.err_drop), 64'd0);
    tick();

    // Cycle table: stream tags 0..3, a bad tag, then the all-ones tag
    vecs.push_back(mk(4'hF, 1'b1, 8'h00, 32'h10, 1'b1, 4'b0000, 1'b0, 32'h0));
    vecs.push_back(mk(4'hF, 1'b1, 8'h01, 32'h11, 1'b1, 4'b0000, 1'b0, 32'h0));
    vecs.push_back(mk(4'hF, 1'b1, 8'h02, 32'h12, 1'b1, 4'b0001, 1'b0, 32'h10));
    vecs.push_back(mk(4'hF, 1'b1, 8'h03, 32'h13, 1'b1, 4'b0010, 1'b0, 32'h11));
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0100, 1'b0, 32'h12));
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b1000, 1'b0, 32'h13));
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0000, 1'b0, 32'h0));
    vecs.push_back(mk(4'hF, 1'b1, 8'h07, 32'hDEAD, 1'b1, 4'b0000, 1'b0, 32'h0));
    vecs.push_back(mk(4'hF, 1'b1, 8'h00, 32'h55, 1'b1, 4'b0000, 1'b1, 32'h0));
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0000, 1'b0, 32'h0));
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0001, 1'b0, 32'h55));
    vecs.push_back(mk(4'hF, 1'b1, 8'hFF, 32'hCAFE, 1'b1, 4'b0000, 1'b0, 32'h0));
`ifdef FUNNEL_FANOUT_BROADCAST_EN
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0000, 1'b0, 32'h0));
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b1111, 1'b0, 32'hCAFE));
`else
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0000, 1'b1, 32'h0));
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0000, 1'b0, 32'h0));
`endif
    vecs.push_back(mk(4'hF, 1'b0, 8'h00, 32'h0,  1'b1, 4'b0000, 1'b0, 32'h0));

    foreach (vecs[k]) begin
      bus.out_enq__RDY = vecs[k].rdy;
      bus.in_enq__ENA  = vecs[k].ena;
      bus.in_enq_v     = {vecs[k].tag, vecs[k].data};
      @(negedge clk);
      check($sformatf("vec%0d_in_rdy", k), 64'(bus.in_enq__RDY), 64'(vecs[k].exp_rdy));
      check($sformatf("vec%0d_out_ena", k), 64'(bus.out_enq__ENA), 64'(vecs[k].exp_ena));
      check($sformatf("vec%0d_err", k), 64'(bus.err_drop), 64'(vecs[k].exp_err));
      for (int i = 0; i < FW; i++) begin
        if (vecs[k].exp_ena[i])
          check($sformatf("vec%0d_lane%0d_data", k, i), 64'(bus.out_enq_v[i*DW +: DW]), 64'(vecs[k].exp_d));
      end
      tick();
    end
    bus.in_enq__ENA = 1'b0;
    repeat (2) tick();
    log_q.delete();

    // Backpressure: lane 1 stalled, A and B fill it, C waits in hold, D waits at input
    bus.out_enq__RDY = 4'b1101;
    send(8'h01, 32'hA);
    send(8'h01, 32'hB);
    send(8'h01, 32'hC);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_in_rdy_low%0d", k), 64'(bus.in_enq__RDY), 64'd0);
      tick();
    end
    check("bp_nothing_out", 64'(log_q.size()), 64'd0);
    bus.out_enq__RDY = 4'b1111;
    send(8'h00, 32'hD);
    wait_log(4, 50);
    check("bp_count", 64'(log_q.size()), 64'd4);
    check_ev("bp", 0, 1, 32'hA);
    check_ev("bp", 1, 1, 32'hB);
    check_ev("bp", 2, 1, 32'hC);
    check_ev("bp", 3, 0, 32'hD);
    log_q.delete();

    // Ten beats to lane 3 while its ready toggles every cycle; pointers wrap
    bus.out_enq__RDY = 4'b1111;
    tog_run = 1'b1;
    fork
      begin
        while (tog_run) begin
          @(posedge clk);
          #2;
          if (tog_run) bus.out_enq__RDY[3] = ~bus.out_enq__RDY[3];
        end
      end
    join_none
    for (int k = 0; k < 10; k++) send(8'h03, 32'h300 + 32'(k));
    wait_log(10, 200);
    tog_run = 1'b0;
    repeat (2) tick();
    bus.out_enq__RDY = 4'b1111;
    check("wrap_count", 64'(log_q.size()), 64'd10);
    for (int k = 0; k < 10; k++) check_ev("wrap", k, 3, 32'h300 + 32'(k));
    log_q.delete();

`ifdef FUNNEL_FANOUT_BROADCAST_EN
    // Broadcast waits for the full lane 2, then reaches all four lanes
    begin
      logic [DW-1:0] per_lane [FW][$];
      bus.out_enq__RDY = 4'b1011;
      send(8'h02, 32'hB1);
      send(8'h02, 32'hB2);
      send(8'hFF, 32'hCAFE);
      repeat (3) tick();
      check("bc_in_rdy_stalled", 64'(bus.in_enq__RDY), 64'd0);
      check("bc_nothing_out", 64'(log_q.size()), 64'd0);
      bus.out_enq__RDY = 4'b1111;
      wait_log(6, 50);
      check("bc_count", 64'(log_q.size()), 64'd6);
      foreach (log_q[k]) per_lane[log_q[k].lane].push_back(log_q[k].data);
      check("bc_lane2_n", 64'(per_lane[2].size()), 64'd3);
      if (per_lane[2].size() == 3) begin
        check("bc_lane2_0", 64'(per_lane[2][0]), 64'hB1);
        check("bc_lane2_1", 64'(per_lane[2][1]), 64'hB2);
        check("bc_lane2_2", 64'(per_lane[2][2]), 64'hCAFE);
      end
      for (int i = 0; i < FW; i++) begin
        if (i != 2) begin
          check($sformatf("bc_lane%0d_n", i), 64'(per_lane[i].size()), 64'd1);
          if (per_lane[i].size() == 1)
            check($sformatf("bc_lane%0d_d", i), 64'(per_lane[i][0]), 64'hCAFE);
        end
      end
      log_q.delete();
    end
`endif

    // Asynchronous reset while lane 2 holds two beats
    bus.out_enq__RDY = 4'b1011;
    send(8'h02, 32'h21);
    send(8'h02, 32'h22);
    repeat (2) tick();
    check("ar_lane2_blocked", 64'(bus.out_enq__ENA[2]), 64'd0);
    bus.out_enq__RDY = 4'b1111;
    #1;
    check("ar_lane2_ready", 64'(bus.out_enq__ENA[2]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("ar_ena_immediate", 64'(bus.out_enq__ENA), 64'd0);
    check("ar_in_rdy", 64'(bus.in_enq__RDY), 64'd1);
    check("ar_err", 64'(bus.err_drop), 64'd0);
    tick();
    rst_n = 1'b1;
    log_q.delete();
    repeat (4) tick();
    check("ar_discarded", 64'(log_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
